// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM for the shared-memory datapath, with memory
// handshake stall, bus-timeout and illegal-opcode trap. Optional perf counters: MC_CTRL_PERF_EN.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef MC_CTRL_PERF_EN
  ,parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       Trap,
  output logic       TrapCause
`ifdef MC_CTRL_PERF_EN
  ,output logic [CNT_W-1:0] InstRet,
  output logic [CNT_W-1:0] CycleCnt
`endif
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4
  // DECODE   | read regs, compute branch/jal target
  // MEMADR   | compute load/store address
  // MEMREAD  | load access
  // MEMWB    | write load data
  // MEMWRITE | store access
  // EXECR    | register ALU op
  // EXECI    | immediate ALU op
  // EXECU    | lui / auipc
  // ALUWB    | write ALUOut
  // BRANCH   | compare, conditional PC update
  // JALR     | compute rs1+imm target
  // JAL      | PC update, link value
  // TRAP     | halted until reset
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] EXECU    = 4'd8;
  localparam logic [3:0] ALUWB    = 4'd9;
  localparam logic [3:0] BRANCH   = 4'd10;
  localparam logic [3:0] JALR     = 4'd11;
  localparam logic [3:0] JAL      = 4'd12;
  localparam logic [3:0] TRAP     = 4'd13;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0] state, state_next;
  logic [7:0] wait_cnt;
  logic       trap_cause, cause_next;
  logic       take, mem_to, is_mem;

  assign is_mem = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // MemReady in the limit cycle takes priority over the timeout
  assign mem_to = !MemReady && (wait_cnt == WAIT_LAST);

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = Zero;
      3'b001:  take = !Zero;
      3'b100:  take = Lt;
      3'b101:  take = !Lt;
      3'b110:  take = Ltu;
      3'b111:  take = !Ltu;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    cause_next = trap_cause;
    MemReq = 1'b0; MemWrite = 1'b0; AdrSrc = 1'b0;
    IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00;
    ImmSrc = 3'b000; ALUOp = 2'b00; Trap = 1'b0;
    case (state)
      FETCH: begin
        MemReq = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        if (MemReady) begin
          IRWrite = 1'b1; PCWrite = 1'b1; state_next = DECODE;
        end else if (mem_to) begin
          state_next = TRAP; cause_next = 1'b1;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        ImmSrc = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LW, OP_SW:     state_next = MEMADR;
          OP_R:             state_next = EXECR;
          OP_I:             state_next = EXECI;
          OP_LUI, OP_AUIPC: state_next = EXECU;
          OP_JAL:           state_next = JAL;
          OP_JALR:          state_next = JALR;
          OP_BR: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
              state_next = TRAP; cause_next = 1'b0;
            end else begin
              state_next = BRANCH;
            end
          end
          default: begin
            state_next = TRAP; cause_next = 1'b0;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        ImmSrc = (op == OP_LW) ? 3'b000 : 3'b001;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        MemReq = 1'b1; AdrSrc = 1'b1;
        if (MemReady) state_next = MEMWB;
        else if (mem_to) begin
          state_next = TRAP; cause_next = 1'b1;
        end
      end
      MEMWB: begin
        ResultSrc = 2'b01; RegWrite = 1'b1; state_next = FETCH;
      end
      MEMWRITE: begin
        MemReq = 1'b1; MemWrite = 1'b1; AdrSrc = 1'b1;
        if (MemReady) state_next = FETCH;
        else if (mem_to) begin
          state_next = TRAP; cause_next = 1'b1;
        end
      end
      EXECR: begin
        ALUSrcA = 2'b10; ALUOp = 2'b10; state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; state_next = ALUWB;
      end
      EXECU: begin
        ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01; ImmSrc = 3'b100; state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1; state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10; ALUOp = 2'b01; PCWrite = take; state_next = FETCH;
      end
      JALR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; state_next = JAL;
      end
      JAL: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; state_next = ALUWB;
      end
      TRAP: Trap = 1'b1;
      default: state_next = FETCH;
    endcase
    TrapCause = trap_cause;
    if (!reset_n) begin
      MemReq = 1'b0; MemWrite = 1'b0; AdrSrc = 1'b0;
      IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0;
      ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00;
      ImmSrc = 3'b000; ALUOp = 2'b00; Trap = 1'b0; TrapCause = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      wait_cnt   <= 8'd0;
      trap_cause <= 1'b0;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
      if (state_next != state || MemReady) wait_cnt <= 8'd0;
      else if (is_mem) wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      InstRet  <= '0;
      CycleCnt <= '0;
    end else begin
      if (state != TRAP) CycleCnt <= CycleCnt + 1'b1;
      if (state_next == FETCH && state != FETCH) InstRet <= InstRet + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_TIMEOUT=4); counter checks only when MC_CTRL_PERF_EN is defined.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, Lt, Ltu, MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Trap, TrapCause;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [2:0] ImmSrc;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] InstRet, CycleCnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_controller #(
    .MEM_TIMEOUT(4)
`ifdef MC_CTRL_PERF_EN
    ,.CNT_W(32)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUOp(ALUOp), .Trap(Trap), .TrapCause(TrapCause)
`ifdef MC_CTRL_PERF_EN
    ,.InstRet(InstRet), .CycleCnt(CycleCnt)
`endif
  );

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUOp,Trap,TrapCause}
  logic [18:0] outs;
  assign outs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp, Trap, TrapCause};

  localparam logic [18:0] E_ZERO     = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_FETCH_W  = {6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_FETCH    = {6'b100110, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] E_DEC_JAL  = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b011, 2'b00, 2'b00};
  localparam logic [18:0] E_MADR_LW  = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_MADR_SW  = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b001, 2'b00, 2'b00};
  localparam logic [18:0] E_MEMREAD  = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_MEMWB    = {6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_MEMWRITE = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_EXECR    = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 2'b00};
  localparam logic [18:0] E_EXECI    = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b10, 2'b00};
  localparam logic [18:0] E_LUI      = {6'b000000, 2'b11, 2'b01, 2'b00, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_AUIPC    = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_BR_TAKE  = {6'b000010, 2'b10, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00};
  localparam logic [18:0] E_BR_NOT   = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00};
  localparam logic [18:0] E_JALR     = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_JAL      = {6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_TRAP0    = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] E_TRAP1    = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b11};

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // check the current state's outputs, then advance one clock
  task automatic cyc(input string tag, input logic [18:0] exp);
    #1;
    chk(tag, {13'd0, outs}, {13'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_outputs", {13'd0, outs}, {13'd0, E_ZERO});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; op = 7'b0110011; funct3 = 3'b000;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; MemReady = 1'b1;
    do_reset();
`ifdef MC_CTRL_PERF_EN
    #1;
    chk("reset_instret", InstRet, 32'd0);
    chk("reset_cyclecnt", CycleCnt, 32'd0);
    @(negedge clk);
    // re-sync so the perf window starts at release
    do_reset();
`endif

    // jalr, lui, auipc: 5 + 4 + 4 cycles
    op = 7'b1100111;
    cyc("jalr_fetch", E_FETCH); cyc("jalr_decode", E_DECODE);
    cyc("jalr_jalr", E_JALR); cyc("jalr_jal", E_JAL); cyc("jalr_wb", E_ALUWB);
    op = 7'b0110111;
    cyc("lui_fetch", E_FETCH); cyc("lui_decode", E_DECODE);
    cyc("lui_exec", E_LUI); cyc("lui_wb", E_ALUWB);
    op = 7'b0010111;
    cyc("auipc_fetch", E_FETCH); cyc("auipc_decode", E_DECODE);
    cyc("auipc_exec", E_AUIPC); cyc("auipc_wb", E_ALUWB);
`ifdef MC_CTRL_PERF_EN
    #1;
    chk("perf_instret", InstRet, 32'd3);
    chk("perf_cyclecnt", CycleCnt, 32'd13);
`endif

    // add, zero wait
    op = 7'b0110011;
    cyc("add_fetch", E_FETCH); cyc("add_decode", E_DECODE);
    cyc("add_exec", E_EXECR); cyc("add_wb", E_ALUWB);
    // addi
    op = 7'b0010011;
    cyc("addi_fetch", E_FETCH); cyc("addi_decode", E_DECODE);
    cyc("addi_exec", E_EXECI); cyc("addi_wb", E_ALUWB);

    // lw with 3 not-ready cycles: 8 cycles total
    op = 7'b0000011;
    cyc("lw_fetch", E_FETCH); cyc("lw_decode", E_DECODE); cyc("lw_madr", E_MADR_LW);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", E_MEMREAD);
    MemReady = 1'b1;
    cyc("lw_memread_rdy", E_MEMREAD); cyc("lw_memwb", E_MEMWB);

    // sw
    op = 7'b0100011;
    cyc("sw_fetch", E_FETCH); cyc("sw_decode", E_DECODE);
    cyc("sw_madr", E_MADR_SW); cyc("sw_memwrite", E_MEMWRITE);

    // jal
    op = 7'b1101111;
    cyc("jal_fetch", E_FETCH); cyc("jal_decode", E_DEC_JAL);
    cyc("jal_jal", E_JAL); cyc("jal_wb", E_ALUWB);

    // branches
    op = 7'b1100011;
    funct3 = 3'b001; Zero = 1'b0;
    cyc("bne_fetch", E_FETCH); cyc("bne_decode", E_DECODE); cyc("bne_taken", E_BR_TAKE);
    Zero = 1'b1;
    cyc("bne2_fetch", E_FETCH); cyc("bne2_decode", E_DECODE); cyc("bne_not_taken", E_BR_NOT);
    funct3 = 3'b000;
    cyc("beq_fetch", E_FETCH); cyc("beq_decode", E_DECODE); cyc("beq_taken", E_BR_TAKE);
    funct3 = 3'b100; Lt = 1'b1; Zero = 1'b0;
    cyc("blt_fetch", E_FETCH); cyc("blt_decode", E_DECODE); cyc("blt_taken", E_BR_TAKE);
    funct3 = 3'b101;
    cyc("bge_fetch", E_FETCH); cyc("bge_decode", E_DECODE); cyc("bge_not_taken", E_BR_NOT);
    funct3 = 3'b110; Ltu = 1'b0;
    cyc("bltu_fetch", E_FETCH); cyc("bltu_decode", E_DECODE); cyc("bltu_not_taken", E_BR_NOT);
    funct3 = 3'b111;
    cyc("bgeu_fetch", E_FETCH); cyc("bgeu_decode", E_DECODE); cyc("bgeu_taken", E_BR_TAKE);
    funct3 = 3'b010;
    cyc("bbad_fetch", E_FETCH); cyc("bbad_decode", E_DECODE);
    cyc("bbad_trap", E_TRAP0); cyc("bbad_trap_hold", E_TRAP0);
    do_reset();

    // illegal opcode 0000000: trap held 20 cycles, reset recovers
    op = 7'b0000000; funct3 = 3'b000;
    cyc("ill_fetch", E_FETCH); cyc("ill_decode", E_DECODE);
    for (int i = 0; i < 20; i++) cyc("ill_trap", E_TRAP0);
    do_reset();
    op = 7'b0110011;
    cyc("ill_recover_fetch", E_FETCH); cyc("ill_recover_decode", E_DECODE);
    do_reset();

    // fetch timeout: 4 not-ready cycles -> trap cause 1
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_fetch_wait", E_FETCH_W);
    cyc("to_trap", E_TRAP1); cyc("to_trap_hold", E_TRAP1);
    do_reset();
    // ready on the 4th cycle wins
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("nto_fetch_wait", E_FETCH_W);
    MemReady = 1'b1;
    cyc("nto_fetch_rdy", E_FETCH); cyc("nto_decode", E_DECODE);
    cyc("nto_exec", E_EXECR); cyc("nto_wb", E_ALUWB);

    // store timeout
    op = 7'b0100011;
    cyc("swto_fetch", E_FETCH); cyc("swto_decode", E_DECODE); cyc("swto_madr", E_MADR_SW);
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) cyc("swto_wait", E_MEMWRITE);
    cyc("swto_trap", E_TRAP1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle RV32I control unit: Moore FSM that sequences fetch, decode, execute, memory and writeback for the shared-memory multicycle datapath. Generalises the single-cycle/pipelined main decoder: covers jalr, lui, auipc and all six branch conditions, stalls on a memory ready handshake, and traps on illegal opcodes or memory timeout. Sits beside the ALU decoder, which consumes ALUOp.

## Interface
- MEM_TIMEOUT, 15: max consecutive not-ready cycles in a memory state before bus-error trap (1..255).
- CNT_W, 32: perf counter width (only with MC_CTRL_PERF_EN).
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode (from IR).
- funct3  in  3  instruction funct3.
- Zero, Lt, Ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access requested.
- MemWrite  out  1  store request (qualifies MemReq).
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite, PCWrite, RegWrite  out  1 each  register enables.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUOp  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- Trap  out  1  sticky trap indicator.
- TrapCause  out  1  0 illegal instruction, 1 bus timeout.
- InstRet, CycleCnt  out  CNT_W each  (only with MC_CTRL_PERF_EN).

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, EXECU, ALUWB, BRANCH, JALR, JAL, TRAP.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite pulse only in the cycle MemReady=1; then DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=011 if op=jal else 010. Next: lw 0000011/sw 0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 0110111/0010111→EXECU; 1100011→BRANCH (funct3 010/011 → TRAP, cause 0); 1101111→JAL; 1100111→JALR; any other op (incl. 0000000)→TRAP, cause 0.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000 (lw) / 001 (sw); →MEMREAD or MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1; on MemReady→MEMWB. MEMWB: ResultSrc=01, RegWrite=1; →FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1; on MemReady→FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=10. EXECU: ALUSrcA=11 (lui) / 01 (auipc), ALUSrcB=01, ImmSrc=100, ALUOp=00. All →ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; →FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=take, take per funct3: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu; →FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=00; →JAL. JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; →ALUWB.
- Memory timeout: wait counter clears on entering a memory state and on MemReady; increments each not-ready cycle; reaching MEM_TIMEOUT with MemReady=0 →TRAP, cause 1. MemReady in the same cycle as the limit wins (normal transition).
- TRAP: all enables and MemReq 0, Trap=1; held until reset. TrapCause latched on entry.
- Unlisted outputs are 0 in each state.

## Timing
- Reset (async): state=FETCH, wait counter 0, Trap=0, TrapCause=0, counters 0; all outputs forced 0 while reset_n low. First fetch request in first cycle after release.
- Cycles with MemReady tied 1: branch 3; R/I/lui/auipc/sw 4; lw, jal 4/5 (jal 4, jalr 5, lw 5). Each not-ready cycle adds one.
- Outputs are Moore except IRWrite/PCWrite in FETCH (gated by MemReady) and PCWrite in BRANCH (flags).

## Configuration
- MC_CTRL_PERF_EN defined: CycleCnt increments every non-reset cycle outside TRAP; InstRet increments on each transition into FETCH from a non-FETCH state; both wrap modulo 2^CNT_W.
- Undefined: counters and ports absent; no other change.

## Test plan
- Zero-wait add (op 0110011): FETCH→DECODE→EXECR→ALUWB→FETCH, RegWrite=1 only in cycle 4.
- lw with MemReady low 3 cycles in MEMREAD: instruction takes 8 cycles; RegWrite with ResultSrc=01 once.
- bne funct3=001, Zero=0 → PCWrite=1 in BRANCH; Zero=1 → PCWrite=0; funct3=010 → Trap=1, TrapCause=0.
- op=0000000 at DECODE → TRAP, all enables 0 for 20 cycles; reset_n pulse returns to FETCH.
- MEM_TIMEOUT=4, MemReady held 0 in FETCH → Trap=1, TrapCause=1 after 4 wait cycles; repeat with MemReady=1 on cycle 4 → no trap.
- With MC_CTRL_PERF_EN: jalr, lui, auipc sequence (5+4+4 cycles) → InstRet=3, CycleCnt=13.
